key_event_encoder: RTL and testbench

//  Sits directly downstream of the keypad debouncer. Consumes the debounced

---
 rtl/key_event_encoder.sv | 149 ++++++++++++++
 tb/tb_key_event_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// Key event encoder: turns debounced key presses into key codes with
// auto-repeat, queued in a FIFO drained by a valid/ready handshake.
// Ports: clk_500hz, rst_n (async low), isPressed[N*N], key_code/key_valid/
//        key_ready (FIFO head handshake), multi_key, overflow (drop pulse).
module key_event_encoder #(
  parameter int N            = 5,
  parameter int DEPTH        = 4,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 50
) (
  input  logic                     clk_500hz,
  input  logic                     rst_n,
  input  logic [N*N-1:0]           isPressed,
  output logic [$clog2(N*N)-1:0]   key_code,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic                     multi_key,
  output logic                     overflow
);

  localparam int CW   = $clog2(N*N);
  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] DLY_END  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_END = TW'(REPEAT_RATE - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_RPT
  } state_t;

  state_t          state, state_nx;
  logic [N*N-1:0]  prev;
  logic [N*N-1:0]  rise;
  logic [CW-1:0]   idx, idx_nx;
  logic [CW-1:0]   hit_idx;
  logic [TW-1:0]   cnt, cnt_nx;
  logic            one_hot, many;
  logic            push;
  logic [CW-1:0]   push_code;

  logic [CW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     count;
  logic            full, pop, wr_ok;

  assign rise    = isPressed & ~prev;
  assign one_hot = $onehot(isPressed);
  assign many    = !$onehot0(isPressed);

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < N*N; i++)
      if (isPressed[i]) hit_idx = CW'(i);
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt;
    push      = 1'b0;
    push_code = idx;
    case (state)
      S_IDLE: begin
        if (one_hot && rise[hit_idx]) begin
          push      = 1'b1;
          push_code = hit_idx;
          idx_nx    = hit_idx;
          cnt_nx    = '0;
          state_nx  = S_HELD;
        end
      end
      S_HELD: begin
        if (!isPressed[idx]) begin
          state_nx = S_IDLE;
        end else if (REPEAT_DELAY != 0) begin
          if (cnt == DLY_END) begin
            push     = 1'b1;
            cnt_nx   = '0;
            state_nx = S_RPT;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_RPT: begin
        if (!isPressed[idx]) begin
          state_nx = S_IDLE;
        end else if (cnt == RATE_END) begin
          push   = 1'b1;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_500hz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prev      <= '0;
      idx       <= '0;
      cnt       <= '0;
      multi_key <= 1'b0;
    end else begin
      state     <= state_nx;
      prev      <= isPressed;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      multi_key <= (state_nx == S_IDLE) && many;
    end
  end

  assign full      = (count == FULL_CNT);
  assign key_valid = (count != '0);
  assign pop       = key_valid & key_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_ok     = push && (!full || pop);
  assign key_code  = key_valid ? mem[rp] : '0;

  always_ff @(posedge clk_500hz) begin
    if (wr_ok) mem[wp] <= push_code;
  end

  always_ff @(posedge clk_500hz or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop)   rp <= rp + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed scenarios plus random key
// traffic, every cycle compared against an event-level reference model.
module tb_key_event_encoder;

  localparam int N     = 5;
  localparam int NK    = N*N;
  localparam int DEPTH = 4;
  localparam int RD    = 250;
  localparam int RR    = 50;

  logic            clk_500hz = 1'b0;
  logic            rst_n     = 1'b1;
  logic [NK-1:0]   isPressed = '0;
  logic [4:0]      key_code;
  logic            key_valid;
  logic            key_ready = 1'b1;
  logic            multi_key;
  logic            overflow;

  key_event_encoder #(
    .N(N), .DEPTH(DEPTH),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk_500hz(clk_500hz),
    .rst_n(rst_n),
    .isPressed(isPressed),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .multi_key(multi_key),
    .overflow(overflow)
  );

  always #5 clk_500hz = ~clk_500hz;

  int n_vec = 0;
  int n_err = 0;

  int            m_idx;
  int            m_t;
  logic [NK-1:0] m_prev;
  int            q[$];
  bit            m_multi;
  bit            m_ovf;
  int            acc[$];
  int            ovf_seen;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_idx   = -1;
    m_t     = 0;
    m_prev  = '0;
    m_multi = 0;
    m_ovf   = 0;
    q.delete();
  endtask

  task automatic model_edge();
    bit pop;
    bit push;
    int code;
    pop  = (q.size() > 0) && key_ready;
    push = 0;
    code = 0;
    if (m_idx < 0) begin
      if ($countones(isPressed) == 1 &&
          (isPressed & ~m_prev) != '0) begin
        for (int i = 0; i < NK; i++)
          if (isPressed[i]) code = i;
        push  = 1;
        m_idx = code;
        m_t   = 0;
      end
    end else if (!isPressed[m_idx]) begin
      m_idx = -1;
    end else if (RD != 0) begin
      m_t++;
      if (m_t == RD || (m_t > RD && (m_t - RD) % RR == 0)) begin
        push = 1;
        code = m_idx;
      end
    end
    m_multi = (m_idx < 0) && ($countones(isPressed) > 1);
    if (pop) void'(q.pop_front());
    m_ovf = 0;
    if (push) begin
      if (q.size() < DEPTH) q.push_back(code);
      else m_ovf = 1;
    end
    m_prev = isPressed;
  endtask

  task automatic check_outs();
    chk("valid", key_valid, q.size() > 0);
    chk("code", key_code, (q.size() > 0) ? q[0] : 0);
    chk("multi", multi_key, m_multi);
    chk("ovf", overflow, m_ovf);
  endtask

  task automatic tick(input logic [NK-1:0] p, input logic r);
    isPressed = p;
    key_ready = r;
    #1;
    if (key_valid && key_ready) acc.push_back(key_code);
    @(posedge clk_500hz);
    model_edge();
    #1;
    check_outs();
    if (overflow) ovf_seen++;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_multi", multi_key, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk_500hz);
    @(posedge clk_500hz);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [NK-1:0] k(input int i);
    logic [NK-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [NK-1:0] pat;
    int dur;
    int total;
    int sel;

    do_reset();

    acc.delete();
    repeat (10) tick(k(7), 1);
    repeat (5) tick('0, 1);
    chk("t1_n", acc.size(), 1);
    if (acc.size() > 0) chk("t1_code", acc[0], 7);

    acc.delete();
    repeat (400) tick(k(3), 1);
    repeat (5) tick('0, 1);
    chk("t2_n", acc.size(), 4);
    foreach (acc[i]) chk("t2_code", acc[i], 3);

    acc.delete();
    repeat (5) tick(k(2) | k(9), 1);
    chk("t3_multi1", multi_key, 1);
    repeat (5) tick(k(2), 1);
    chk("t3_multi0", multi_key, 0);
    chk("t3_n", acc.size(), 0);
    repeat (3) tick('0, 1);

    acc.delete();
    ovf_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(k(i), 0);
      tick('0, 0);
    end
    chk("t4_ovf", ovf_seen, 1);
    repeat (6) tick('0, 1);
    chk("t4_n", acc.size(), 4);
    foreach (acc[i]) chk("t4_order", acc[i], i + 1);

    acc.delete();
    for (int i = 10; i <= 13; i++) begin
      tick(k(i), 0);
      tick('0, 0);
    end
    tick(k(14), 1);
    chk("t5_ovf", overflow, 0);
    chk("t5_head", key_code, 11);
    repeat (6) tick('0, 1);
    chk("t5_n", acc.size(), 5);
    foreach (acc[i]) chk("t5_order", acc[i], 10 + i);

    repeat (260) tick(k(6), 0);
    chk("t6_pre", key_valid, 1);
    do_reset();
    acc.delete();
    repeat (10) tick(k(6), 1);
    repeat (3) tick('0, 1);
    chk("t6_n", acc.size(), 1);
    if (acc.size() > 0) chk("t6_code", acc[0], 6);

    total = 0;
    pat = '0;
    while (total < 20000) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        pat = '0;
        dur = $urandom_range(1, 5);
      end else if (sel < 8) begin
        pat = k($urandom_range(0, NK - 1));
        dur = $urandom_range(1, 360);
      end else begin
        pat = pat | k($urandom_range(0, NK - 1));
        dur = $urandom_range(1, 20);
      end
      repeat (dur) tick(pat, $urandom_range(0, 3) != 0);
      total += dur;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
